// File: rtl/hdc_pkg.sv
// Shared encodings and FSM state type for the HDC batch sequencer.
package hdc_pkg;

    localparam logic signed [1:0] LBL_SPAM = 2'sb01;
    localparam logic signed [1:0] LBL_HAM  = 2'sb11;
    localparam logic signed [1:0] LBL_TIE  = 2'sb00;

    localparam int DEF_MAX_LENGTH = 200;
    localparam int MSG_W          = DEF_MAX_LENGTH * 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_SCORE,
        ST_DONE
    } state_t;

    function automatic int msg_bits(input int max_length);
        return max_length * 8;
    endfunction

endpackage

// File: rtl/hdc_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module hdc_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hdc_batch_ctrl.sv
// Sequences a ROM batch of messages into the HDC classifier and scores each
// result against its label, with a watchdog guarding every classification.
//
// State | Meaning
// IDLE  | waiting for start
// FETCH | ROM read in flight
// LOAD  | latch ROM word onto the HDC bus
// ISSUE | msg_valid pulse, arm watchdog
// WAIT  | waiting for compute_done or watchdog expiry
// SCORE | bump exactly one statistics counter
// DONE  | batch_done pulse; loop or return to IDLE
module hdc_batch_ctrl
    import hdc_pkg::*;
#(
    parameter int MAX_LENGTH = 200,
    parameter int NUM_MSGS   = 16,
    parameter int IDX_W      = $clog2(NUM_MSGS),
    parameter int TIMEOUT    = 4096,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              loop_mode,
    output logic [IDX_W-1:0]                  rom_addr,
    input  logic [msg_bits(MAX_LENGTH)-1:0]   rom_msg,
    input  logic [7:0]                        rom_length,
    input  logic [1:0]                        rom_label,
    output logic [msg_bits(MAX_LENGTH)-1:0]   msg,
    output logic [7:0]                        length,
    output logic [1:0]                        label,
    output logic                              msg_valid,
    input  logic                              compute_done,
    input  logic [1:0]                        result,
    input  logic                              hdc_error,
    output logic                              busy,
    output logic                              batch_done,
    output logic [CNT_W-1:0]                  correct_cnt,
    output logic [CNT_W-1:0]                  wrong_cnt,
    output logic [CNT_W-1:0]                  timeout_cnt,
    output logic [CNT_W-1:0]                  err_cnt,
    output logic [IDX_W-1:0]                  last_bad_idx
);

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSGS - 1);

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer;
    logic [1:0]       cap_result;
    logic             cap_err;
    logic             timed_out;

    logic clr_cnt;
    logic inc_correct, inc_wrong, inc_timeout, inc_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt     = 1'b0;
        inc_correct = 1'b0;
        inc_wrong   = 1'b0;
        inc_timeout = 1'b0;
        inc_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    clr_cnt   = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                // A completion on the expiry cycle wins over the timeout.
                if (compute_done || (timer == '0)) begin
                    state_nxt = ST_SCORE;
                end
            end
            ST_SCORE: begin
                if (timed_out) begin
                    inc_timeout = 1'b1;
                end else if (cap_err) begin
                    inc_err = 1'b1;
                end else if (cap_result == label) begin
                    inc_correct = 1'b1;
                end else begin
                    inc_wrong = 1'b1;
                end
                state_nxt = (rom_addr == LAST_IDX) ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                if (loop_mode) begin
                    clr_cnt   = 1'b1;
                    state_nxt = ST_FETCH;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr     <= '0;
            msg          <= '0;
            length       <= '0;
            label        <= '0;
            timer        <= '0;
            cap_result   <= '0;
            cap_err      <= 1'b0;
            timed_out    <= 1'b0;
            last_bad_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rom_addr <= '0;
                    end
                end
                ST_LOAD: begin
                    msg    <= rom_msg;
                    length <= rom_length;
                    label  <= rom_label;
                end
                ST_ISSUE: begin
                    // Watchdog counts down; terminal count is the expiry cycle.
                    timer     <= TMR_W'(TIMEOUT - 1);
                    timed_out <= 1'b0;
                end
                ST_WAIT: begin
                    if (timer != '0) begin
                        timer <= timer - TMR_W'(1);
                    end
                    if (compute_done) begin
                        cap_result <= result;
                        cap_err    <= hdc_error;
                    end else if (timer == '0) begin
                        timed_out <= 1'b1;
                    end
                end
                ST_SCORE: begin
                    if (inc_wrong || inc_timeout || inc_err) begin
                        last_bad_idx <= rom_addr;
                    end
                    if (rom_addr != LAST_IDX) begin
                        rom_addr <= rom_addr + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (loop_mode) begin
                        rom_addr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign msg_valid  = (state == ST_ISSUE);
    assign batch_done = (state == ST_DONE);
    assign busy       = (state != ST_IDLE) && (state != ST_DONE);

    hdc_sat_counter #(.CNT_W(CNT_W)) u_correct_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (inc_correct),
        .count (correct_cnt)
    );

    hdc_sat_counter #(.CNT_W(CNT_W)) u_wrong_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (inc_wrong),
        .count (wrong_cnt)
    );

    hdc_sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (inc_timeout),
        .count (timeout_cnt)
    );

    hdc_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (inc_err),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_hdc_batch_ctrl.sv
// Bench for hdc_batch_ctrl: random ROM contents and HDC behaviour per message,
// scored by a per-message outcome model.
module tb_hdc_batch_ctrl;
    import hdc_pkg::*;

    localparam int ML   = 4;
    localparam int NM   = 8;
    localparam int IW   = 3;
    localparam int TO   = 32;
    localparam int CW   = 3;
    localparam int MW   = ML * 8;
    localparam int CMAX = (1 << CW) - 1;

    typedef enum int {K_OK, K_WRONG, K_TIE, K_ERR, K_SILENT, K_LATE, K_EXACT} kind_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          loop_mode = 1'b0;
    logic [IW-1:0] rom_addr;
    logic [MW-1:0] rom_msg;
    logic [7:0]    rom_length;
    logic [1:0]    rom_label;
    logic [MW-1:0] msg;
    logic [7:0]    length;
    logic [1:0]    label;
    logic          msg_valid;
    logic          compute_done = 1'b0;
    logic [1:0]    result = 2'b00;
    logic          hdc_error = 1'b0;
    logic          busy, batch_done;
    logic [CW-1:0] correct_cnt, wrong_cnt, timeout_cnt, err_cnt;
    logic [IW-1:0] last_bad_idx;

    int n_cmp = 0;
    int n_bad = 0;

    logic [MW-1:0] mem_msg   [NM];
    logic [7:0]    mem_len   [NM];
    logic [1:0]    mem_label [NM];

    kind_t      plan_k [NM];
    int         plan_d [NM];
    logic [1:0] plan_r [NM];
    logic       plan_e [NM];

    int            obs_idx [$];
    logic [MW-1:0] obs_msg [$];
    logic [7:0]    obs_len [$];
    logic [1:0]    obs_lbl [$];
    int            n_done = 0;
    int            pend = 0;
    logic [1:0]    pend_res = 2'b00;
    logic          pend_err = 1'b0;

    always #5 clk = ~clk;

    hdc_batch_ctrl #(
        .MAX_LENGTH (ML),
        .NUM_MSGS   (NM),
        .TIMEOUT    (TO),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .loop_mode    (loop_mode),
        .rom_addr     (rom_addr),
        .rom_msg      (rom_msg),
        .rom_length   (rom_length),
        .rom_label    (rom_label),
        .msg          (msg),
        .length       (length),
        .label        (label),
        .msg_valid    (msg_valid),
        .compute_done (compute_done),
        .result       (result),
        .hdc_error    (hdc_error),
        .busy         (busy),
        .batch_done   (batch_done),
        .correct_cnt  (correct_cnt),
        .wrong_cnt    (wrong_cnt),
        .timeout_cnt  (timeout_cnt),
        .err_cnt      (err_cnt),
        .last_bad_idx (last_bad_idx)
    );

    // Registered ROM with one cycle of read latency.
    always @(posedge clk) begin
        rom_msg    <= mem_msg[rom_addr];
        rom_length <= mem_len[rom_addr];
        rom_label  <= mem_label[rom_addr];
    end

    // HDC model: delay d means compute_done is high d cycles after the issue cycle.
    always @(negedge clk) begin
        compute_done = 1'b0;
        hdc_error    = 1'b0;
        result       = 2'b00;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    compute_done = 1'b1;
                    result       = pend_res;
                    hdc_error    = pend_err;
                end
            end
            if (batch_done) n_done = n_done + 1;
            if (msg_valid) begin
                obs_idx.push_back(int'(rom_addr));
                obs_msg.push_back(msg);
                obs_len.push_back(length);
                obs_lbl.push_back(label);
                if (plan_k[rom_addr] != K_SILENT) begin
                    pend     = plan_d[rom_addr];
                    pend_res = plan_r[rom_addr];
                    pend_err = plan_e[rom_addr];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_rom();
        for (int i = 0; i < NM; i++) begin
            mem_msg[i]   = MW'($urandom);
            mem_len[i]   = 8'($urandom_range(1, ML));
            mem_label[i] = ($urandom_range(0, 1) == 1) ? LBL_SPAM : LBL_HAM;
        end
    endtask

    task automatic set_plan(input int i, input kind_t k, input int d);
        plan_k[i] = k;
        plan_d[i] = d;
        plan_e[i] = 1'b0;
        case (k)
            K_OK:    plan_r[i] = mem_label[i];
            K_WRONG: plan_r[i] = (mem_label[i] == LBL_SPAM) ? LBL_HAM : LBL_SPAM;
            K_TIE:   plan_r[i] = LBL_TIE;
            K_ERR: begin
                plan_r[i] = ($urandom_range(0, 1) == 1) ? mem_label[i] : LBL_TIE;
                plan_e[i] = 1'b1;
            end
            K_SILENT: begin plan_r[i] = LBL_TIE; plan_d[i] = 0; end
            K_LATE:   begin plan_r[i] = mem_label[i]; plan_d[i] = TO + 2; end
            default:  begin plan_r[i] = mem_label[i]; plan_d[i] = TO; end
        endcase
    endtask

    task automatic random_plan();
        for (int i = 0; i < NM; i++)
            set_plan(i, kind_t'($urandom_range(0, 6)), $urandom_range(1, 20));
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Outcome per message straight from the scoring rules.
    task automatic check_stats(input string tag);
        int c = 0, w = 0, t = 0, e = 0, lb = -1;
        for (int i = 0; i < NM; i++) begin
            if (plan_k[i] == K_SILENT || plan_d[i] > TO) begin t++; lb = i; end
            else if (plan_e[i]) begin e++; lb = i; end
            else if (plan_r[i] == mem_label[i]) c++;
            else begin w++; lb = i; end
        end
        chk({tag, "_correct"}, 64'(correct_cnt), 64'(sat(c)));
        chk({tag, "_wrong"},   64'(wrong_cnt),   64'(sat(w)));
        chk({tag, "_timeout"}, 64'(timeout_cnt), 64'(sat(t)));
        chk({tag, "_err"},     64'(err_cnt),     64'(sat(e)));
        if (lb >= 0) chk({tag, "_last_bad"}, 64'(last_bad_idx), 64'(lb));
    endtask

    task automatic check_issues(input string tag, input int base);
        int bad = 0;
        chk({tag, "_n_valid"}, 64'(obs_idx.size() - base), 64'(NM));
        for (int i = 0; i < NM && base + i < obs_idx.size(); i++) begin
            if (obs_idx[base+i] != i) bad++;
            else if (obs_msg[base+i] !== mem_msg[i] || obs_len[base+i] !== mem_len[i] ||
                     obs_lbl[base+i] !== mem_label[i]) bad++;
        end
        chk({tag, "_issue_payload_errs"}, 64'(bad), 64'd0);
    endtask

    task automatic start_batch(input string tag, input bit poke);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        chk({tag, "_addr_after_start"}, 64'(rom_addr), 64'd0);
        if (poke) begin
            repeat (15) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (!batch_done && c < 4000) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_done_seen"}, 64'(batch_done), 64'd1);
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    endtask

    task automatic run_batch(input string tag, input bit poke);
        int base = obs_idx.size();
        int dbase = n_done;
        start_batch(tag, poke);
        wait_done(tag);
        check_stats(tag);
        @(negedge clk);
        chk({tag, "_done_pulse_len"}, 64'(batch_done), 64'd0);
        chk({tag, "_n_done"}, 64'(n_done - dbase), 64'd1);
        check_issues(tag, base);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"},  64'(rom_addr), 64'd0);
        chk({tag, "_msg"},   64'(msg), 64'd0);
        chk({tag, "_bus"},   64'({length, label, msg_valid, busy, batch_done}), 64'd0);
        chk({tag, "_cnts"},  64'({correct_cnt, wrong_cnt, timeout_cnt, err_cnt}), 64'd0);
        chk({tag, "_lbad"},  64'(last_bad_idx), 64'd0);
    endtask

    initial begin
        int c, base, dbase;
        bit saw_done;
        load_rom();
        for (int i = 0; i < NM; i++) set_plan(i, K_OK, 10);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // All correct: correct_cnt saturates at CMAX with 8 messages.
        run_batch("all_ok", 1'b1);

        // Tie on index 2.
        load_rom();
        for (int i = 0; i < NM; i++) set_plan(i, K_OK, 3 + i);
        set_plan(2, K_TIE, 5);
        run_batch("tie2", 1'b0);

        // Silent HDC on index 1, completion on the exact expiry cycle on index 3,
        // late response landing in the next FETCH from index 5.
        for (int i = 0; i < NM; i++) set_plan(i, K_WRONG, 1);
        set_plan(1, K_SILENT, 0);
        set_plan(3, K_EXACT, 0);
        set_plan(5, K_LATE, 0);
        set_plan(6, K_OK, 1);
        set_plan(7, K_ERR, 20);
        run_batch("edges", 1'b0);

        for (int r = 0; r < 5; r++) begin
            load_rom();
            random_plan();
            run_batch($sformatf("rand%0d", r), 1'b1);
        end

        // Reset during WAIT of index 2.
        load_rom();
        for (int i = 0; i < NM; i++) set_plan(i, K_OK, 2);
        set_plan(1, K_WRONG, 2);
        set_plan(2, K_SILENT, 0);
        base = obs_idx.size();
        dbase = n_done;
        start_batch("mid_rst", 1'b0);
        c = 0;
        while (obs_idx.size() < base + 3 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("mid_rst_reached_idx2", 64'(obs_idx.size() - base), 64'd3);
        repeat (4) @(negedge clk);
        chk("mid_rst_pre_wrong", 64'(wrong_cnt), 64'd1);
        chk("mid_rst_pre_lbad", 64'(last_bad_idx), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("mid_rst");
        @(negedge clk) rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (batch_done || busy) saw_done = 1'b1;
        end
        chk("mid_rst_no_done", 64'({saw_done, 32'(n_done - dbase)}), 64'd0);

        // Loop mode: two back-to-back batches, counters clear between them.
        load_rom();
        random_plan();
        set_plan(0, K_WRONG, 4);
        loop_mode = 1'b1;
        base = obs_idx.size();
        start_batch("loop1", 1'b0);
        wait_done("loop1");
        check_stats("loop1");
        check_issues("loop1", base);
        @(negedge clk);
        chk("loop_restart_busy", 64'(busy), 64'd1);
        chk("loop_restart_addr", 64'(rom_addr), 64'd0);
        chk("loop_restart_cnts", 64'({correct_cnt, wrong_cnt, timeout_cnt, err_cnt}), 64'd0);
        loop_mode = 1'b0;
        base = obs_idx.size();
        wait_done("loop2");
        check_stats("loop2");
        @(negedge clk);
        chk("loop2_idle", 64'({busy, batch_done}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
